// File: rtl/uart_stream_xcvr.sv
// uart_stream_xcvr: configurable full-duplex UART with buffered RX stream
// and ready/valid handshakes on both directions.
module uart_stream_xcvr #(
  parameter int CLKS_PER_BIT  = 32,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             rx,
  output logic                             tx,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic [1:0]                       rx_err,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
  output logic                             rx_overrun,
  input  logic                             clr_overrun,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx_busy
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BITN  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOPN = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULLN = (AW+1)'(RX_FIFO_DEPTH);
  localparam bit   HAS_PAR = (PARITY != 0);
  localparam logic ODD     = (PARITY == 2);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rst_q <= '0;
    else       rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic rx_m, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT
  } rx_state_t;

  rx_state_t            rs, rs_n;
  logic [CW-1:0]        rcnt, rcnt_n;
  logic [BW-1:0]        rbit, rbit_n;
  logic [DATA_BITS-1:0] rsh, rsh_n;
  logic                 rpe, rpe_n;
  logic                 push;
  logic [1:0]           push_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs   <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh  <= '0;
      rpe  <= 1'b0;
    end else begin
      rs   <= rs_n;
      rcnt <= rcnt_n;
      rbit <= rbit_n;
      rsh  <= rsh_n;
      rpe  <= rpe_n;
    end
  end

  always_comb begin
    rs_n     = rs;
    rcnt_n   = rcnt + CW'(1);
    rbit_n   = rbit;
    rsh_n    = rsh;
    rpe_n    = rpe;
    push     = 1'b0;
    push_err = {rpe, ~rx_s};
    unique case (rs)
      R_IDLE: begin
        rcnt_n = '0;
        rbit_n = '0;
        rpe_n  = 1'b0;
        if (!rx_s) rs_n = R_START;
      end
      R_START: if (rcnt == HALF) begin
        rcnt_n = '0;
        rs_n   = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (rcnt == BITN) begin
        rcnt_n = '0;
        rsh_n  = {rx_s, rsh[DATA_BITS-1:1]};
        rbit_n = rbit + BW'(1);
        if (rbit == LAST) rs_n = HAS_PAR ? R_PAR : R_STOP;
      end
      R_PAR: if (rcnt == BITN) begin
        rcnt_n = '0;
        rpe_n  = ((^rsh) ^ rx_s) != ODD;
        rs_n   = R_STOP;
      end
      R_STOP: if (rcnt == BITN) begin
        rcnt_n = '0;
        push   = 1'b1;
        rs_n   = rx_s ? R_IDLE : R_WAIT;
      end
      R_WAIT: begin
        rcnt_n = '0;
        if (rx_s) rs_n = R_IDLE;
      end
      default: rs_n = R_IDLE;
    endcase
  end

  logic [DATA_BITS+1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [AW:0]          cnt;
  logic                 full, pop, wr;

  assign full = (cnt == FULLN);
  assign pop  = rx_valid && rx_ready;
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {push_err, rsh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (wr && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (!wr && pop) cnt <= cnt - (AW+1)'(1);
      if (push && full && !pop) rx_overrun <= 1'b1;
      else if (clr_overrun)     rx_overrun <= 1'b0;
    end
  end

  assign rx_valid = (cnt != '0);
  assign rx_count = cnt;
  assign rx_data  = rx_valid ? mem[rp][DATA_BITS-1:0] : '0;
  assign rx_err   = rx_valid ? mem[rp][DATA_BITS+1:DATA_BITS] : '0;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  tx_state_t            ts, ts_n;
  logic [CW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        tbit, tbit_n;
  logic [DATA_BITS-1:0] tsh, tsh_n;
  logic                 tpar, tpar_n;
  logic                 tx_q, tx_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts   <= T_IDLE;
      tcnt <= '0;
      tbit <= '0;
      tsh  <= '0;
      tpar <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      ts   <= ts_n;
      tcnt <= tcnt_n;
      tbit <= tbit_n;
      tsh  <= tsh_n;
      tpar <= tpar_n;
      tx_q <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle, so tx stays a flop output.
  always_comb begin
    ts_n   = ts;
    tcnt_n = tcnt + CW'(1);
    tbit_n = tbit;
    tsh_n  = tsh;
    tpar_n = tpar;
    tx_n   = tx_q;
    unique case (ts)
      T_IDLE: begin
        tcnt_n = '0;
        tbit_n = '0;
        tx_n   = 1'b1;
        if (tx_valid) begin
          ts_n   = T_START;
          tsh_n  = tx_data;
          tpar_n = (^tx_data) ^ ODD;
          tx_n   = 1'b0;
        end
      end
      T_START: if (tcnt == BITN) begin
        tcnt_n = '0;
        ts_n   = T_DATA;
        tx_n   = tsh[0];
      end
      T_DATA: if (tcnt == BITN) begin
        tcnt_n = '0;
        tbit_n = tbit + BW'(1);
        tsh_n  = tsh >> 1;
        if (tbit == LAST) begin
          ts_n = HAS_PAR ? T_PAR : T_STOP;
          tx_n = HAS_PAR ? tpar : 1'b1;
        end else begin
          tx_n = tsh[1];
        end
      end
      T_PAR: if (tcnt == BITN) begin
        tcnt_n = '0;
        ts_n   = T_STOP;
        tx_n   = 1'b1;
      end
      T_STOP: if (tcnt == STOPN) begin
        tcnt_n = '0;
        ts_n   = T_IDLE;
        tx_n   = 1'b1;
      end
      default: ts_n = T_IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (ts == T_IDLE);
  assign tx_busy  = (ts != T_IDLE);

endmodule

// File: tb/tb_uart_stream_xcvr.sv
// tb_uart_stream_xcvr: directed scoreboard bench for the UART transceiver
// covering 8N1 RX, 8E1 loopback, break, overrun/wrap, 7N2 TX and glitches.
module tb_uart_stream_xcvr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rstN = 1'b0;
  logic c_rstN = 1'b0;

  logic       a_rx = 1'b1, a_tx;
  logic [7:0] a_rx_data;
  logic [1:0] a_rx_err;
  logic       a_rx_valid, a_rx_ready = 1'b0;
  logic [4:0] a_rx_count;
  logic       a_rx_overrun, a_clr = 1'b0;
  logic [7:0] a_tx_data = '0;
  logic       a_tx_valid = 1'b0, a_tx_ready, a_tx_busy;

  logic       b_rx, b_tx, b_flip = 1'b0;
  logic [7:0] b_rx_data;
  logic [1:0] b_rx_err;
  logic       b_rx_valid, b_rx_ready = 1'b0;
  logic [4:0] b_rx_count;
  logic       b_rx_overrun;
  logic [7:0] b_tx_data = '0;
  logic       b_tx_valid = 1'b0, b_tx_ready, b_tx_busy;
  assign b_rx = b_tx ^ b_flip;

  logic       c_rx = 1'b1, c_tx;
  logic [6:0] c_rx_data;
  logic [1:0] c_rx_err;
  logic       c_rx_valid;
  logic [4:0] c_rx_count;
  logic       c_rx_overrun;
  logic [6:0] c_tx_data = '0;
  logic       c_tx_valid = 1'b0, c_tx_ready, c_tx_busy;

  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [6:0] qc[$];

  uart_stream_xcvr dut_a (
    .clk(clk), .rstN(rstN), .rx(a_rx), .tx(a_tx),
    .rx_data(a_rx_data), .rx_err(a_rx_err), .rx_valid(a_rx_valid),
    .rx_ready(a_rx_ready), .rx_count(a_rx_count),
    .rx_overrun(a_rx_overrun), .clr_overrun(a_clr),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .tx_busy(a_tx_busy)
  );

  uart_stream_xcvr #(.PARITY(1)) dut_b (
    .clk(clk), .rstN(rstN), .rx(b_rx), .tx(b_tx),
    .rx_data(b_rx_data), .rx_err(b_rx_err), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .rx_count(b_rx_count),
    .rx_overrun(b_rx_overrun), .clr_overrun(1'b0),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .tx_busy(b_tx_busy)
  );

  uart_stream_xcvr #(.DATA_BITS(7), .STOP_BITS(2)) dut_c (
    .clk(clk), .rstN(c_rstN), .rx(c_rx), .tx(c_tx),
    .rx_data(c_rx_data), .rx_err(c_rx_err), .rx_valid(c_rx_valid),
    .rx_ready(1'b0), .rx_count(c_rx_count),
    .rx_overrun(c_rx_overrun), .clr_overrun(1'b0),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid),
    .tx_ready(c_tx_ready), .tx_busy(c_tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_bits(input logic [7:0] d);
    a_rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a_rx = d[i];
      repeat (32) @(negedge clk);
    end
    a_rx = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic pop_a(input string tag);
    logic [9:0] e;
    int n = 0;
    while (!a_rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(a_rx_valid), 32'(1'b1));
    e = (qa.size() != 0) ? qa.pop_front() : 10'bx;
    check({tag, " data"}, 32'(a_rx_data), 32'(e[7:0]));
    check({tag, " err"}, 32'(a_rx_err), 32'(e[9:8]));
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
  endtask

  task automatic pop_b(input string tag);
    logic [9:0] e;
    int n = 0;
    while (!b_rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(b_rx_valid), 32'(1'b1));
    e = (qb.size() != 0) ? qb.pop_front() : 10'bx;
    check({tag, " data"}, 32'(b_rx_data), 32'(e[7:0]));
    check({tag, " err"}, 32'(b_rx_err), 32'(e[9:8]));
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
  endtask

  // Handshake lands on the posedge between the two negedges; the parity
  // bit then occupies cycles 288..319 after it.
  task automatic b_send(input logic [7:0] d, input logic flip);
    int n = 0;
    while (!b_tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    b_tx_data = d;
    b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
    qb.push_back({flip, 1'b0, d});
    if (flip) begin
      repeat (291) @(negedge clk);
      b_flip = 1'b1;
      repeat (24) @(negedge clk);
      b_flip = 1'b0;
    end
  endtask

  task automatic wait_c_fall();
    int n = 0;
    while (c_tx !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("c_fall", 32'(c_tx), 32'(1'b0));
  endtask

  initial begin
    int lat;
    int falls[3];
    logic [6:0] cd[3];
    logic [6:0] got;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    rstN = 1'b1;
    c_rstN = 1'b1;
    repeat (4) @(negedge clk);

    check("rst tx", 32'(a_tx), 32'(1'b1));
    check("rst tx_ready", 32'(a_tx_ready), 32'(1'b1));
    check("rst tx_busy", 32'(a_tx_busy), 32'(1'b0));
    check("rst rx_valid", 32'(a_rx_valid), 32'(1'b0));
    check("rst rx_err", 32'(a_rx_err), 32'(2'b00));
    check("rst rx_count", 32'(a_rx_count), 32'(5'd0));
    check("rst rx_overrun", 32'(a_rx_overrun), 32'(1'b0));
    check("rst b tx", 32'(b_tx), 32'(1'b1));
    check("rst c tx", 32'(c_tx), 32'(1'b1));

    qa.push_back({2'b00, 8'hA5});
    lat = 0;
    fork
      a_bits(8'hA5);
      begin
        while (!a_rx_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("rx latency 306..308", 32'(lat >= 306 && lat <= 308), 32'(1'b1));
    check("rx count one", 32'(a_rx_count), 32'(5'd1));
    pop_a("8n1 a5");

    a_rx = 1'b0;
    repeat (8) @(negedge clk);
    a_rx = 1'b1;
    repeat (64) @(negedge clk);
    check("glitch count", 32'(a_rx_count), 32'(5'd0));
    check("glitch valid", 32'(a_rx_valid), 32'(1'b0));
    qa.push_back({2'b00, 8'h3C});
    a_bits(8'h3C);
    pop_a("after glitch");

    qa.push_back({2'b01, 8'h00});
    a_rx = 1'b0;
    repeat (640) @(negedge clk);
    check("break count low", 32'(a_rx_count), 32'(5'd1));
    a_rx = 1'b1;
    repeat (64) @(negedge clk);
    check("break count high", 32'(a_rx_count), 32'(5'd1));
    qa.push_back({2'b00, 8'h55});
    a_bits(8'h55);
    check("break then 55 count", 32'(a_rx_count), 32'(5'd2));
    pop_a("break entry");
    pop_a("post break 55");

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 17; i++) begin
        d = 8'(i * 13 + p * 7 + 1);
        if (i < 16) qa.push_back({2'b00, d});
        a_bits(d);
      end
      check("ovr count", 32'(a_rx_count), 32'(5'd16));
      check("ovr flag", 32'(a_rx_overrun), 32'(1'b1));
      check("ovr head", 32'(a_rx_data), 32'(qa[0][7:0]));
      for (int i = 0; i < 16; i++) pop_a("drain");
      check("drain count", 32'(a_rx_count), 32'(5'd0));
      check("ovr sticky", 32'(a_rx_overrun), 32'(1'b1));
      a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      check("ovr cleared", 32'(a_rx_overrun), 32'(1'b0));
    end

    b_send(8'h00, 1'b0);
    b_send(8'hFF, 1'b0);
    b_send(8'h3C, 1'b0);
    repeat (400) @(negedge clk);
    for (int i = 0; i < 3; i++) pop_b("8e1 pass1");
    b_send(8'h00, 1'b0);
    b_send(8'hFF, 1'b1);
    b_send(8'h3C, 1'b0);
    repeat (400) @(negedge clk);
    for (int i = 0; i < 3; i++) pop_b("8e1 pass2");
    check("8e1 overrun", 32'(b_rx_overrun), 32'(1'b0));

    cd[0] = 7'h35;
    cd[1] = 7'h4A;
    cd[2] = 7'h01;
    for (int i = 0; i < 3; i++) qc.push_back(cd[i]);
    c_tx_data = cd[0];
    c_tx_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_c_fall();
      falls[f] = cyc;
      check("c busy", 32'(c_tx_busy), 32'(1'b1));
      check("c ready low", 32'(c_tx_ready), 32'(1'b0));
      c_tx_data = (f < 2) ? cd[f+1] : 7'h7F;
      if (f == 2) c_tx_valid = 1'b0;
      repeat (15) @(negedge clk);
      check("c start bit", 32'(c_tx), 32'(1'b0));
      for (int i = 0; i < 7; i++) begin
        repeat (32) @(negedge clk);
        got[i] = c_tx;
      end
      repeat (32) @(negedge clk);
      check("c stop1", 32'(c_tx), 32'(1'b1));
      repeat (32) @(negedge clk);
      check("c stop2", 32'(c_tx), 32'(1'b1));
      check("c frame data", 32'(got),
            32'((qc.size() != 0) ? qc.pop_front() : 7'bx));
      if (f > 0)
        check("c frame gap", 32'(falls[f] - falls[f-1]), 32'(321));
    end
    repeat (40) @(negedge clk);
    check("c idle after stream", 32'(c_tx_ready), 32'(1'b1));

    c_tx_data = 7'h2B;
    c_tx_valid = 1'b1;
    wait_c_fall();
    c_tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("c mid-frame bit low", 32'(c_tx), 32'(1'b0));
    c_rstN = 1'b0;
    #1;
    check("c reset tx", 32'(c_tx), 32'(1'b1));
    check("c reset busy", 32'(c_tx_busy), 32'(1'b0));
    @(negedge clk);
    c_rstN = 1'b1;
    repeat (4) @(negedge clk);
    check("c post-reset ready", 32'(c_tx_ready), 32'(1'b1));
    repeat (400) @(negedge clk);
    check("c no resumed frame", 32'(c_tx), 32'(1'b1));
    check("c idle busy", 32'(c_tx_busy), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
